// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Arbitrates data-memory wait, EX-stage redirect and load-use hazards,
// drives PC / pipeline-register enables and flushes, and keeps
// saturating stall/flush counters plus a sticky memory-timeout flag.
//
// Control outputs are Mealy: a combinational function of the registered
// state and the current hazard inputs. Priority is mem wait, then
// redirect, then load-use.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_id_rs1_addr,
   input  logic [4:0]       i_id_rs2_addr,
   input  logic [4:0]       i_ex_rd_addr,
   input  logic             i_ex_mem_rden,
   input  logic             i_ex_pc_src,
   input  logic             i_mem_req,
   input  logic             i_dmem_ready,
   input  logic             i_cnt_clr,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_en,
   output logic             o_id_ex_flush,
   output logic             o_ex_mem_en,
   output logic             o_mem_wb_flush,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic             o_mem_err
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     state_q;
   state_t     state_nxt;
   logic       mw;
   logic       rd;
   logic       lu;
   logic [7:0] wait_q;
   logic [7:0] wait_nxt;
   logic       stall_inc;
   logic       flush_inc;

   // Hazard terms; load-use is masked in LU_STALL so a stall lasts one cycle.
   assign mw = i_mem_req & ~i_dmem_ready;
   assign rd = i_ex_pc_src;
   assign lu = i_ex_mem_rden & (i_ex_rd_addr != 5'd0)
             & ((i_ex_rd_addr == i_id_rs1_addr) | (i_ex_rd_addr == i_id_rs2_addr))
             & (state_q != LU_STALL);

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic. Leaving MEM_WAIT follows the RUN rules, so a
   // load-use held behind the wait still ends in a single-cycle stall.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         RUN: begin
            if (mw)            state_nxt = MEM_WAIT;
            else if (lu && !rd) state_nxt = LU_STALL;
         end
         LU_STALL: begin
            if (mw) state_nxt = MEM_WAIT;
            else    state_nxt = RUN;
         end
         MEM_WAIT: begin
            if (!mw) begin
               if (lu && !rd) state_nxt = LU_STALL;
               else           state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // Output logic: reset bubbles everything, otherwise prioritised hazards.
   always_comb begin
      o_pc_en        = 1'b1;
      o_if_id_en     = 1'b1;
      o_if_id_flush  = 1'b0;
      o_id_ex_en     = 1'b1;
      o_id_ex_flush  = 1'b0;
      o_ex_mem_en    = 1'b1;
      o_mem_wb_flush = 1'b0;
      if (i_reset) begin
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_id_ex_en     = 1'b0;
         o_ex_mem_en    = 1'b0;
         o_if_id_flush  = 1'b1;
         o_id_ex_flush  = 1'b1;
         o_mem_wb_flush = 1'b1;
      end else if (mw) begin
         // Freeze the front of the pipe; WB gets a bubble meanwhile.
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_id_ex_en     = 1'b0;
         o_ex_mem_en    = 1'b0;
         o_mem_wb_flush = 1'b1;
      end else if (rd) begin
         // PC loads the target; squash IF and ID (any load-use is moot).
         o_if_id_flush  = 1'b1;
         o_id_ex_flush  = 1'b1;
      end else if (lu) begin
         // Hold PC and if_id, inject a bubble into EX.
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_id_ex_flush  = 1'b1;
      end
   end

   assign o_state = state_q;

   // Wait-cycle count: the cycle that enters MEM_WAIT counts as the first.
   always_comb begin
      wait_nxt = wait_q;
      if (mw) begin
         if (state_q != MEM_WAIT)  wait_nxt = 8'd1;
         else if (wait_q != 8'hFF) wait_nxt = wait_q + 8'd1;
      end
   end

   // Wait counter and sticky timeout flag (only reset clears the flag).
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wait_q    <= 8'd0;
         o_mem_err <= 1'b0;
      end else begin
         wait_q <= wait_nxt;
         if (mw && (wait_nxt == TIMEOUT)) o_mem_err <= 1'b1;
      end
   end

   assign stall_inc = ~o_pc_en;
   assign flush_inc = rd & ~mw;

   // Saturating performance counters; clear beats increment.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else if (i_cnt_clr) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (stall_inc && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + 1'b1;
         if (flush_inc && (o_flush_cnt != '1)) o_flush_cnt <= o_flush_cnt + 1'b1;
      end
   end

endmodule
